// File: rtl/df_i_coeff_ctrl_pkg.sv
// df_pkg: definitions shared by the df_i filter and its coefficient controller.
//   state_t        - controller FSM encoding (IDLE / FLUSH / SETTLE)
//   clog2          - constant ceil(log2(v))
//   addr_width     - clog2 clamped to a minimum of 1 bit
//   DF_* defaults  - default filter order and coefficient width, shared with df_i
package df_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FLUSH  = 2'd1,
        SETTLE = 2'd2
    } state_t;

    localparam int DF_N_DEFAULT           = 1;
    localparam int DF_COEFF_WIDTH_DEFAULT = 4;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) r = i + 1;
        end
        return r;
    endfunction

    function automatic int addr_width(input int v);
        return (clog2(v) < 1) ? 1 : clog2(v);
    endfunction

endpackage

// File: rtl/df_i_coeff_ctrl_if.sv
// Coefficient configuration port of df_i_coeff_ctrl.
//   cfg_valid/cfg_addr/cfg_data - coefficient write request (master -> slave)
//   cfg_commit                  - swap-and-flush pulse        (master -> slave)
//   cfg_ready                   - write/commit accepted        (slave -> master)
//   cfg_err                     - illegal address / busy access pulse (slave -> master)
interface df_i_coeff_ctrl_if #(
    parameter int ADDR_WIDTH  = 1,
    parameter int COEFF_WIDTH = 4
);
    logic                   cfg_valid;
    logic                   cfg_ready;
    logic [ADDR_WIDTH-1:0]  cfg_addr;
    logic [COEFF_WIDTH-1:0] cfg_data;
    logic                   cfg_commit;
    logic                   cfg_err;

    modport master (
        output cfg_valid, cfg_addr, cfg_data, cfg_commit,
        input  cfg_ready, cfg_err
    );

    modport slave (
        input  cfg_valid, cfg_addr, cfg_data, cfg_commit,
        output cfg_ready, cfg_err
    );
endinterface

// File: rtl/df_i_coeff_ctrl_bank.sv
// df_coeff_bank: shadow and active coefficient register banks.
//   wr_en/wr_addr/wr_data - shadow write (caller guarantees wr_addr is in range)
//   swap                  - copy shadow into active; a same-cycle write is
//                           included in the copied bank
//   packed_active         - active bank, coefficient i at [i*COEFF_WIDTH +: COEFF_WIDTH]
module df_coeff_bank #(
    parameter int NUM_COEFFS  = 2,
    parameter int COEFF_WIDTH = 4,
    parameter int ADDR_WIDTH  = 1
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              wr_en,
    input  logic [ADDR_WIDTH-1:0]             wr_addr,
    input  logic [COEFF_WIDTH-1:0]            wr_data,
    input  logic                              swap,
    output logic [NUM_COEFFS*COEFF_WIDTH-1:0] packed_active
);

    logic [NUM_COEFFS-1:0][COEFF_WIDTH-1:0] shadow, shadow_nx, active;

    // Per-coefficient next shadow value; the swap copies shadow_nx so a write
    // landing in the commit cycle is merged into the new active bank.
    for (genvar i = 0; i < NUM_COEFFS; i++) begin : g_coef
        assign shadow_nx[i] = (wr_en && wr_addr == ADDR_WIDTH'(i)) ? wr_data : shadow[i];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            shadow <= '0;
            active <= '0;
        end else begin
            shadow <= shadow_nx;
            if (swap) active <= shadow_nx;
        end
    end

    assign packed_active = active;

endmodule

// File: rtl/df_i_coeff_ctrl.sv
// df_i_coeff_ctrl: configuration controller for the df_i direct-form-I IIR filter.
//   clk, rst       - clock and synchronous active-high reset
//   cfg            - coefficient write/commit port (slave modport)
//   busy           - controller not in IDLE
//   packed_coeffs  - active coefficient bank driven to df_i
//   filt_rst_n     - active-low reset to df_i (low during FLUSH)
//   filt_out_valid - df_i output meaningful (high only in IDLE)
// A commit swaps shadow->active, holds df_i in reset for FLUSH_CYCLES, then
// masks its output for SETTLE_CYCLES while the delay line refills.
module df_i_coeff_ctrl
    import df_pkg::*;
#(
    parameter int N             = DF_N_DEFAULT,
    parameter int COEFF_WIDTH   = DF_COEFF_WIDTH_DEFAULT,
    parameter int NUM_COEFFS    = 2 * N,
    parameter int ADDR_WIDTH    = addr_width(NUM_COEFFS),
    parameter int FLUSH_CYCLES  = N + 1,
    parameter int SETTLE_CYCLES = N + 1
) (
    input  logic                              clk,
    input  logic                              rst,
    df_i_coeff_ctrl_if.slave                  cfg,
    output logic                              busy,
    output logic [NUM_COEFFS*COEFF_WIDTH-1:0] packed_coeffs,
    output logic                              filt_rst_n,
    output logic                              filt_out_valid
);

    localparam int CNT_MAX = (FLUSH_CYCLES > SETTLE_CYCLES) ? FLUSH_CYCLES : SETTLE_CYCLES;
    localparam int CNT_W   = addr_width(CNT_MAX);
    // One extra bit so the range check stays meaningful when NUM_COEFFS is a power of two.
    localparam logic [ADDR_WIDTH:0] NC_EXT = (ADDR_WIDTH + 1)'(NUM_COEFFS);

    state_t           state, state_d;
    logic [CNT_W-1:0] cnt, cnt_d;
    logic             idle, addr_ok, wr_fire, swap;
    logic             busy_d, ready_d, rst_n_d, valid_d, err_d;

    assign idle    = (state == IDLE);
    assign addr_ok = ({1'b0, cfg.cfg_addr} < NC_EXT);
    assign wr_fire = idle && cfg.cfg_valid && addr_ok;
    assign swap    = idle && cfg.cfg_commit;

    // State register plus registered outputs (outputs follow state_d so they
    // line up with the state they describe).
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= FLUSH;
            cnt            <= CNT_W'(FLUSH_CYCLES - 1);
            busy           <= 1'b1;
            cfg.cfg_ready  <= 1'b0;
            filt_rst_n     <= 1'b0;
            filt_out_valid <= 1'b0;
            cfg.cfg_err    <= 1'b0;
        end else begin
            state          <= state_d;
            cnt            <= cnt_d;
            busy           <= busy_d;
            cfg.cfg_ready  <= ready_d;
            filt_rst_n     <= rst_n_d;
            filt_out_valid <= valid_d;
            cfg.cfg_err    <= err_d;
        end
    end

    // Next-state and counter.
    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        case (state)
            IDLE: begin
                if (cfg.cfg_commit) begin
                    state_d = FLUSH;
                    cnt_d   = CNT_W'(FLUSH_CYCLES - 1);
                end
            end
            FLUSH: begin
                if (cnt == '0) begin
                    if (SETTLE_CYCLES > 0) begin
                        state_d = SETTLE;
                        cnt_d   = CNT_W'(SETTLE_CYCLES - 1);
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d = cnt - 1'b1;
                end
            end
            SETTLE: begin
                if (cnt == '0) state_d = IDLE;
                else           cnt_d   = cnt - 1'b1;
            end
            default: begin
                state_d = FLUSH;
                cnt_d   = CNT_W'(FLUSH_CYCLES - 1);
            end
        endcase
    end

    // Output decode from the upcoming state.
    always_comb begin
        busy_d  = (state_d != IDLE);
        ready_d = (state_d == IDLE);
        rst_n_d = (state_d != FLUSH);
        valid_d = (state_d == IDLE);
        // Any access while busy is an error; in IDLE only an out-of-range write is.
        err_d   = idle ? (cfg.cfg_valid && !addr_ok) : (cfg.cfg_valid || cfg.cfg_commit);
    end

    df_coeff_bank #(
        .NUM_COEFFS  (NUM_COEFFS),
        .COEFF_WIDTH (COEFF_WIDTH),
        .ADDR_WIDTH  (ADDR_WIDTH)
    ) u_bank (
        .clk           (clk),
        .rst           (rst),
        .wr_en         (wr_fire),
        .wr_addr       (cfg.cfg_addr),
        .wr_data       (cfg.cfg_data),
        .swap          (swap),
        .packed_active (packed_coeffs)
    );

endmodule
